id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 5-stage RISC-V core. It registers the operands read from the register file (data_rs1/data_rs2), the decoded immediate and the control bundle for the EX stage. It detects load-use hazards against the instruction it currently holds, inserts bubbles, and honours branch flush and downstream memory stall. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width
- REG_WIDTH, 32, data/PC/immediate width
- CTRL_WIDTH, 12, opaque EX/MEM/WB control bundle width
- CNT_WIDTH, 16, performance counter width

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID slot holds a real instruction
- id_pc  in  REG_WIDTH  PC of ID instruction
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_WIDTH  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  REG_WIDTH  register file read data
- id_imm  in  REG_WIDTH  sign-extended immediate
- id_ctrl  in  CTRL_WIDTH  control bundle
- id_reg_write, id_mem_read, id_mem_write  in  1  side-effect controls, kept separate for bubble gating
- ex_branch_taken  in  1  EX resolved a taken branch/jump; flush
- mem_stall  in  1  downstream stall; hold all contents
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  REG_WIDTH  registered
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  REG_ADDR_WIDTH  registered, for the forwarding unit
- ex_ctrl  out  CTRL_WIDTH  registered
- stall_if_id  out  1  combinational; freeze PC and IF/ID
- perf_stall_cnt, perf_flush_cnt  out  CNT_WIDTH  event counters

## Operation
- The load-use condition is load_use = ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & ((id_uses_rs1 & id_rs1_addr == ex_rd_addr) | (id_uses_rs2 & id_rs2_addr == ex_rd_addr)).
- The stage register update follows this priority, highest first:
  1. Reset: every output register is 0.
  2. Flush (ex_branch_taken=1): load a bubble, even if mem_stall=1.
  3. Hold (mem_stall=1): all registers keep their value.
  4. Load-use: load a bubble.
  5. Otherwise: load all id_* fields. ex_valid gets id_valid. If id_valid=0, the control bits are forced 0.
- A bubble sets ex_valid, ex_reg_write, ex_mem_read and ex_mem_write to 0, and zeroes every other field. Bubbles are deterministic.
- stall_if_id = ~ex_branch_taken & (mem_stall | load_use).
- perf_stall_cnt increments by 1 in each cycle that rule 4 applies.
- perf_flush_cnt increments by 1 in each cycle that rule 2 applies while id_valid=1.
- Both counters saturate at all-ones and never wrap. They clear only on reset.

## Timing
- Latency is 1 cycle from ID inputs to ex_* outputs.
- A load-use hazard costs exactly one bubble cycle. On the next edge the load has moved out of the stage, so load_use drops and the held ID instruction enters.
- stall_if_id has no registered delay. It is valid in the same cycle as its inputs.
- Reset mid-operation takes effect immediately and asynchronously: outputs and counters go to 0 and any in-flight instruction is lost.
- The register file writes on negedge, so ID read data already reflects a WB write from the same cycle. This stage has no WB bypass.

## Structure
- The shared core package holds:
  - the ctrl bundle field index constants
  - the bubble constant
  - CNT_WIDTH
- One sub-module is natural: hazard_detect, the combinational load_use/stall_if_id logic.
- Everything else is a single registered process plus the counter logic.

## Test plan
- Reset: hold rst_n=0 with random inputs. Then all ex_* = 0, stall_if_id = 0 (given mem_stall=0 and ex_branch_taken=0), and both counters = 0.
- Normal flow: id_pc=0x100, id_rs1_data=0x5, id_rd_addr=3, id_valid=1. After one edge, ex_pc=0x100, ex_rs1_data=0x5, ex_rd_addr=3, ex_valid=1.
- Load-use:
  - Stimulus: lw x5 held in the stage (ex_mem_read=1, ex_rd_addr=5); ID add with id_rs1_addr=5, id_uses_rs1=1.
  - Required: stall_if_id=1; the next edge gives ex_valid=0 and perf_stall_cnt=1; on the following edge the add enters.
  - Repeat with ex_rd_addr=0: no stall.
- Flush beats stall: ex_branch_taken=1 with mem_stall=1 and id_valid=1. Then the next edge gives ex_valid=0, perf_flush_cnt increments, and stall_if_id=0.
- Hold: mem_stall=1 for 3 cycles with changing id_* inputs. ex_* stays unchanged and stall_if_id=1.
- Saturation: force 2^CNT_WIDTH+2 load-use events. perf_stall_cnt stays at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for the ID/EX stage: control bundle layout,
// side-effect bubble constant and performance counter width.
package id_ex_stage_pkg;

  localparam int unsigned CTRL_ALU_OP_LSB   = 0;
  localparam int unsigned CTRL_ALU_OP_MSB   = 3;
  localparam int unsigned CTRL_ALU_SRC      = 4;
  localparam int unsigned CTRL_BRANCH       = 5;
  localparam int unsigned CTRL_JUMP         = 6;
  localparam int unsigned CTRL_MEM_SIZE_LSB = 7;
  localparam int unsigned CTRL_MEM_SIZE_MSB = 8;
  localparam int unsigned CTRL_MEM_UNSIGNED = 9;
  localparam int unsigned CTRL_WB_SEL_LSB   = 10;
  localparam int unsigned CTRL_WB_SEL_MSB   = 11;
  localparam int unsigned CTRL_BUNDLE_WIDTH = 12;

  localparam int unsigned CORE_CNT_WIDTH = 16;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } side_ctrl_t;

  localparam side_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detection against the instruction held in EX,
// and the resulting IF/ID freeze request.
module id_ex_stage_hazard_detect #(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      i_ex_valid,
  input  logic                      i_ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd_addr,
  input  logic                      i_id_valid,
  input  logic                      i_id_uses_rs1,
  input  logic                      i_id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr,
  input  logic                      i_ex_branch_taken,
  input  logic                      i_mem_stall,
  output logic                      o_load_use,
  output logic                      o_stall_if_id
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  always_comb begin
    w_rs1_hit = i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
    w_rs2_hit = i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr);
    o_load_use = i_ex_valid && i_ex_mem_read && (i_ex_rd_addr != '0) &&
                 i_id_valid && (w_rs1_hit || w_rs2_hit);
    // A taken branch discards the ID instruction, so never freeze on it.
    o_stall_if_id = !i_ex_branch_taken && (i_mem_stall || o_load_use);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling, branch flush, downstream
// hold and saturating stall/flush event counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned CTRL_WIDTH     = CTRL_BUNDLE_WIDTH,
  parameter int unsigned CNT_WIDTH      = CORE_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_WIDTH-1:0]      id_pc,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_WIDTH-1:0]      id_rs1_data,
  input  logic [REG_WIDTH-1:0]      id_rs2_data,
  input  logic [REG_WIDTH-1:0]      id_imm,
  input  logic [CTRL_WIDTH-1:0]     id_ctrl,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      ex_branch_taken,
  input  logic                      mem_stall,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic [REG_WIDTH-1:0]      ex_pc,
  output logic [REG_WIDTH-1:0]      ex_rs1_data,
  output logic [REG_WIDTH-1:0]      ex_rs2_data,
  output logic [REG_WIDTH-1:0]      ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic [CTRL_WIDTH-1:0]     ex_ctrl,
  output logic                      stall_if_id,
  output logic [CNT_WIDTH-1:0]      perf_stall_cnt,
  output logic [CNT_WIDTH-1:0]      perf_flush_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  side_ctrl_t                r_side;
  logic [REG_WIDTH-1:0]      r_pc;
  logic [REG_WIDTH-1:0]      r_rs1_data;
  logic [REG_WIDTH-1:0]      r_rs2_data;
  logic [REG_WIDTH-1:0]      r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] r_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
  logic [CTRL_WIDTH-1:0]     r_ctrl;
  logic [CNT_WIDTH-1:0]      r_stall_cnt;
  logic [CNT_WIDTH-1:0]      r_flush_cnt;

  logic w_load_use;
  logic w_stall_if_id;
  logic w_bubble;
  logic w_load;
  logic w_stall_evt;
  logic w_flush_evt;

  id_ex_stage_hazard_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .i_ex_valid       (r_side.valid),
    .i_ex_mem_read    (r_side.mem_read),
    .i_ex_rd_addr     (r_rd_addr),
    .i_id_valid       (id_valid),
    .i_id_uses_rs1    (id_uses_rs1),
    .i_id_uses_rs2    (id_uses_rs2),
    .i_id_rs1_addr    (id_rs1_addr),
    .i_id_rs2_addr    (id_rs2_addr),
    .i_ex_branch_taken(ex_branch_taken),
    .i_mem_stall      (mem_stall),
    .o_load_use       (w_load_use),
    .o_stall_if_id    (w_stall_if_id)
  );

  // Flush outranks hold; a load-use bubble only applies when not held.
  always_comb begin
    w_stall_evt = !ex_branch_taken && !mem_stall && w_load_use;
    w_flush_evt = ex_branch_taken && id_valid;
    w_bubble    = ex_branch_taken || w_stall_evt;
    w_load      = !ex_branch_taken && !mem_stall && !w_load_use;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_side     <= CTRL_BUBBLE;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_ctrl     <= '0;
    end else if (w_bubble) begin
      r_side     <= CTRL_BUBBLE;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_ctrl     <= '0;
    end else if (w_load) begin
      r_side.valid     <= id_valid;
      r_side.reg_write <= id_valid && id_reg_write;
      r_side.mem_read  <= id_valid && id_mem_read;
      r_side.mem_write <= id_valid && id_mem_write;
      r_pc             <= id_pc;
      r_rs1_data       <= id_rs1_data;
      r_rs2_data       <= id_rs2_data;
      r_imm            <= id_imm;
      r_rs1_addr       <= id_rs1_addr;
      r_rs2_addr       <= id_rs2_addr;
      r_rd_addr        <= id_rd_addr;
      r_ctrl           <= id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush_evt && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign ex_valid       = r_side.valid;
  assign ex_reg_write   = r_side.reg_write;
  assign ex_mem_read    = r_side.mem_read;
  assign ex_mem_write   = r_side.mem_write;
  assign ex_pc          = r_pc;
  assign ex_rs1_data    = r_rs1_data;
  assign ex_rs2_data    = r_rs2_data;
  assign ex_imm         = r_imm;
  assign ex_rs1_addr    = r_rs1_addr;
  assign ex_rs2_addr    = r_rs2_addr;
  assign ex_rd_addr     = r_rd_addr;
  assign ex_ctrl        = r_ctrl;
  assign stall_if_id    = w_stall_if_id;
  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a narrow-counter second
// instance shares the stimulus so saturation is reachable quickly.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [11:0] id_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        ex_branch_taken, mem_stall;

  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [11:0] ex_ctrl;
  logic        stall_if_id;
  logic [15:0] perf_stall_cnt, perf_flush_cnt;

  logic        s_valid, s_reg_write, s_mem_read, s_mem_write;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1_addr, s_rs2_addr, s_rd_addr;
  logic [11:0] s_ctrl;
  logic        s_stall_if_id;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .REG_ADDR_WIDTH(5), .REG_WIDTH(32), .CTRL_WIDTH(12), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_ctrl(ex_ctrl),
    .stall_if_id(stall_if_id), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  id_ex_stage #(
    .REG_ADDR_WIDTH(5), .REG_WIDTH(32), .CTRL_WIDTH(12), .CNT_WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .ex_valid(s_valid), .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read),
    .ex_mem_write(s_mem_write), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
    .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_rs1_addr(s_rs1_addr),
    .ex_rs2_addr(s_rs2_addr), .ex_rd_addr(s_rd_addr), .ex_ctrl(s_ctrl),
    .stall_if_id(s_stall_if_id), .perf_stall_cnt(s_stall_cnt),
    .perf_flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid = 0; id_pc = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = '0; id_rs2_data = '0;
    id_imm = '0; id_ctrl = '0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic id_load(input logic [31:0] pc, input logic [4:0] rd);
    id_idle();
    id_valid = 1; id_pc = pc; id_rd_addr = rd; id_reg_write = 1; id_mem_read = 1;
  endtask

  task automatic id_add(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rd);
    id_idle();
    id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_uses_rs1 = 1;
    id_rd_addr = rd; id_reg_write = 1;
  endtask

  initial begin
    rst_n = 0; ex_branch_taken = 0; mem_stall = 0;
    for (int i = 0; i < 4; i++) begin
      id_valid = 1'($urandom); id_pc = $urandom; id_rs1_addr = 5'($urandom);
      id_rs2_addr = 5'($urandom); id_rd_addr = 5'($urandom);
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_ctrl = 12'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
      tick();
    end
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_ex_pc", 64'(ex_pc), 64'd0);
    check("rst_ex_rs1_data", 64'(ex_rs1_data), 64'd0);
    check("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
    check("rst_ex_rd_addr", 64'(ex_rd_addr), 64'd0);
    check("rst_ex_mem_read", 64'(ex_mem_read), 64'd0);
    check("rst_stall_if_id", 64'(stall_if_id), 64'd0);
    check("rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(perf_flush_cnt), 64'd0);
    id_idle();
    #2 rst_n = 1;
    tick();

    // Normal flow
    id_idle();
    id_valid = 1; id_pc = 32'h100; id_rs1_data = 32'h5; id_rd_addr = 5'd3;
    id_rs2_data = 32'hCAFE; id_imm = 32'hFFFF_FFF0; id_ctrl = 12'hABC; id_reg_write = 1;
    tick();
    check("norm_ex_pc", 64'(ex_pc), 64'h100);
    check("norm_ex_rs1_data", 64'(ex_rs1_data), 64'h5);
    check("norm_ex_rs2_data", 64'(ex_rs2_data), 64'hCAFE);
    check("norm_ex_imm", 64'(ex_imm), 64'hFFFF_FFF0);
    check("norm_ex_rd_addr", 64'(ex_rd_addr), 64'd3);
    check("norm_ex_valid", 64'(ex_valid), 64'd1);
    check("norm_ex_ctrl", 64'(ex_ctrl), 64'hABC);
    check("norm_ex_reg_write", 64'(ex_reg_write), 64'd1);

    // Invalid ID slot: side-effect controls gated off
    id_idle();
    id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_pc = 32'h104;
    tick();
    check("inv_ex_valid", 64'(ex_valid), 64'd0);
    check("inv_ex_reg_write", 64'(ex_reg_write), 64'd0);
    check("inv_ex_mem_read", 64'(ex_mem_read), 64'd0);
    check("inv_ex_mem_write", 64'(ex_mem_write), 64'd0);

    // Load-use on rs1
    id_load(32'h200, 5'd5);
    tick();
    check("lu_load_in_ex", 64'(ex_mem_read), 64'd1);
    id_add(32'h204, 5'd5, 5'd6);
    #1;
    check("lu_stall_if_id", 64'(stall_if_id), 64'd1);
    tick();
    check("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check("lu_bubble_pc", 64'(ex_pc), 64'd0);
    check("lu_stall_cnt", 64'(perf_stall_cnt), 64'd1);
    check("lu_stall_released", 64'(stall_if_id), 64'd0);
    tick();
    check("lu_add_valid", 64'(ex_valid), 64'd1);
    check("lu_add_pc", 64'(ex_pc), 64'h204);
    check("lu_add_rd", 64'(ex_rd_addr), 64'd6);

    // Load-use on rs2
    id_load(32'h210, 5'd9);
    tick();
    id_idle();
    id_valid = 1; id_pc = 32'h214; id_rs2_addr = 5'd9; id_uses_rs2 = 1;
    #1;
    check("lu2_stall_if_id", 64'(stall_if_id), 64'd1);
    tick();
    check("lu2_stall_cnt", 64'(perf_stall_cnt), 64'd2);

    // Load to x0 never stalls
    id_load(32'h220, 5'd0);
    tick();
    id_add(32'h224, 5'd0, 5'd7);
    #1;
    check("x0_no_stall", 64'(stall_if_id), 64'd0);
    tick();
    check("x0_add_pc", 64'(ex_pc), 64'h224);
    check("x0_stall_cnt", 64'(perf_stall_cnt), 64'd2);

    // Flush beats stall
    id_add(32'h300, 5'd1, 5'd2);
    mem_stall = 1; ex_branch_taken = 1;
    #1;
    check("fl_stall_if_id", 64'(stall_if_id), 64'd0);
    tick();
    check("fl_ex_valid", 64'(ex_valid), 64'd0);
    check("fl_ex_pc", 64'(ex_pc), 64'd0);
    check("fl_flush_cnt", 64'(perf_flush_cnt), 64'd1);
    id_idle();
    tick();
    check("fl_idle_flush_cnt", 64'(perf_flush_cnt), 64'd1);
    mem_stall = 0; ex_branch_taken = 0;

    // Hold for 3 cycles with changing ID inputs
    id_add(32'h400, 5'd1, 5'd4);
    id_rs1_data = 32'h1234;
    tick();
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_add(32'h500 + 32'(i * 4), 5'd2, 5'(i + 10));
      id_rs1_data = 32'hDEAD_0000 + 32'(i);
      #1;
      check("hold_stall_if_id", 64'(stall_if_id), 64'd1);
      tick();
      check("hold_ex_pc", 64'(ex_pc), 64'h400);
      check("hold_ex_rs1_data", 64'(ex_rs1_data), 64'h1234);
      check("hold_ex_rd_addr", 64'(ex_rd_addr), 64'd4);
    end
    mem_stall = 0;

    // Stall counter saturation (main counter still far from its ceiling)
    for (int i = 0; i < 18; i++) begin
      id_load(32'h600, 5'd7);
      tick();
      id_add(32'h604, 5'd7, 5'd8);
      tick();
    end
    check("sat_narrow_stall_cnt", 64'(s_stall_cnt), 64'hF);
    check("sat_wide_stall_cnt", 64'(perf_stall_cnt), 64'd20);
    check("sat_narrow_flush_cnt", 64'(s_flush_cnt), 64'd1);

    // Asynchronous reset mid-operation
    id_add(32'h700, 5'd3, 5'd3);
    tick();
    #2 rst_n = 0;
    #1;
    check("arst_ex_valid", 64'(ex_valid), 64'd0);
    check("arst_ex_pc", 64'(ex_pc), 64'd0);
    check("arst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
    check("arst_flush_cnt", 64'(perf_flush_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
